// File: rtl/sequenciador_buzzer.sv
// sequenciador_buzzer: plays one of four fixed beep patterns into the buzzer tone generator.
// Define BUZZER_SEQ_PREEMPCAO_EN to let iniciar restart playback while a pattern is running.
module sequenciador_buzzer #(
  parameter int UNIDADE = 100,
  parameter int W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [1:0] padrao,
  output logic       conta,
  output logic [3:0] seletor,
  output logic       tocando,
  output logic       fim
);
  typedef enum logic [1:0] {OCIOSO, TOCA, FIM} estado_t;
  localparam logic [W-1:0] RECARGA = W'(UNIDADE - 1);
  estado_t estado, estado_n;
  logic [1:0] pat, pat_n;
  logic [2:0] passo, passo_n, unids, unids_n;
  logic [W-1:0] cnt, cnt_n;
  logic conta_n, tocando_n, fim_n, pode;
  logic [3:0] seletor_n;
  function automatic logic [3:0] nota(input logic [1:0] p, input logic [2:0] s);
    case ({p, s})
      5'b00_000, 5'b11_011:           nota = 4'b1000;
      5'b01_000, 5'b01_010, 5'b11_000: nota = 4'b0001;
      5'b10_000, 5'b10_010, 5'b10_100, 5'b11_001: nota = 4'b0010;
      5'b11_010:                       nota = 4'b0100;
      default:                         nota = 4'b0000;
    endcase
  endfunction
  function automatic logic [2:0] duracao(input logic [1:0] p, input logic [2:0] s);
    case ({p, s})
      5'b01_000, 5'b01_010, 5'b11_011: duracao = 3'd4;
      5'b01_001, 5'b10_001, 5'b10_011: duracao = 3'd1;
      default:                         duracao = 3'd2;
    endcase
  endfunction
  function automatic logic [2:0] ultimo(input logic [1:0] p);
    ultimo = p == 2'd0 ? 3'd0 : p == 2'd1 ? 3'd2 : p == 2'd2 ? 3'd4 : 3'd3;
  endfunction
`ifdef BUZZER_SEQ_PREEMPCAO_EN
  assign pode = iniciar && !parar;
`else
  assign pode = iniciar && !parar && estado == OCIOSO;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= OCIOSO;
      pat     <= '0;
      passo   <= '0;
      unids   <= '0;
      cnt     <= '0;
      conta   <= 1'b0;
      seletor <= '0;
      tocando <= 1'b0;
      fim     <= 1'b0;
    end else begin
      estado  <= estado_n;
      pat     <= pat_n;
      passo   <= passo_n;
      unids   <= unids_n;
      cnt     <= cnt_n;
      conta   <= conta_n;
      seletor <= seletor_n;
      tocando <= tocando_n;
      fim     <= fim_n;
    end
  end
  // cnt counts cycles within one unit, unids counts units left in the current step
  always_comb begin
    estado_n = estado;
    pat_n    = pat;
    passo_n  = passo;
    unids_n  = unids;
    cnt_n    = cnt;
    case (estado)
      TOCA:
        if (parar) estado_n = OCIOSO;
        else if (cnt != '0) cnt_n = cnt - W'(1);
        else if (unids != 3'd1) begin
          unids_n = unids - 3'd1;
          cnt_n   = RECARGA;
        end else if (passo == ultimo(pat)) estado_n = FIM;
        else begin
          passo_n = passo + 3'd1;
          unids_n = duracao(pat, passo + 3'd1);
          cnt_n   = RECARGA;
        end
      FIM: estado_n = OCIOSO;
      default: ;
    endcase
    if (pode) begin
      estado_n = TOCA;
      pat_n    = padrao;
      passo_n  = '0;
      unids_n  = duracao(padrao, 3'd0);
      cnt_n    = RECARGA;
    end
  end
  always_comb begin
    tocando_n = estado_n == TOCA;
    fim_n     = estado_n == FIM;
    seletor_n = tocando_n ? nota(pat_n, passo_n) : 4'b0000;
    conta_n   = seletor_n != 4'b0000;
  end
endmodule

// File: tb/tb_sequenciador_buzzer.sv
// tb_sequenciador_buzzer: randomized checks of sequenciador_buzzer against a per-cycle trace model.
module tb_sequenciador_buzzer;
  typedef logic [6:0] saida_t;
  typedef saida_t fila_t[$];
  logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0, parar = 1'b0;
  logic [1:0] padrao = 2'd0;
  logic conta, tocando, fim;
  logic [3:0] seletor;
  saida_t obs;
  int vetores = 0, erros = 0;
  int n_passos[4] = '{1, 3, 5, 4};
  logic [3:0] notas[4][5] = '{'{4'h8, 4'h0, 4'h0, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0},
                              '{4'h2, 4'h0, 4'h2, 4'h0, 4'h2}, '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0}};
  int dur[4][5] = '{'{2, 0, 0, 0, 0}, '{4, 1, 4, 0, 0}, '{2, 1, 2, 1, 2}, '{2, 2, 2, 4, 0}};
  assign obs = {conta, seletor, tocando, fim};
  always #5 clock = ~clock;
  sequenciador_buzzer #(.UNIDADE(4), .W(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar), .padrao(padrao),
    .conta(conta), .seletor(seletor), .tocando(tocando), .fim(fim)
  );
  // expected {conta, seletor, tocando, fim} for cycles 1..L+1 after the start edge
  function automatic fila_t traco(input int p);
    fila_t q;
    for (int s = 0; s < n_passos[p]; s++)
      for (int c = 0; c < dur[p][s] * 4; c++) q.push_back({notas[p][s] != 4'h0, notas[p][s], 1'b1, 1'b0});
    q.push_back(7'b0000001);
    return q;
  endfunction
  task automatic test_reset;
    iniciar = 1'b1;
    #1 vetores++;
    if (obs !== 7'b0) begin erros++; $display("FAIL reset_inicial: obtido %b esperado %b", obs, 7'b0); end
    repeat (3) begin
      @(negedge clock);
      vetores++;
      if (obs !== 7'b0) begin erros++; $display("FAIL reset_mantido: obtido %b esperado %b", obs, 7'b0); end
    end
    iniciar = 1'b0;
    reset = 1'b1;
  endtask
  task automatic test_padrao(input int p, input bit mexe);
    fila_t q = traco(p);
    saida_t e;
    padrao = 2'(p);
    iniciar = 1'b1;
    for (int i = 0; i < q.size() + 2; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      e = i < q.size() ? q[i] : 7'b0;
      vetores++;
      if (obs !== e) begin erros++; $display("FAIL padrao%0d ciclo %0d: obtido %b esperado %b", p, i + 1, obs, e); end
      if (mexe) padrao = 2'($urandom);
    end
  endtask
  task automatic test_parar(input int p, input int k_in);
    fila_t q = traco(p);
    saida_t e;
    int k = k_in != 0 ? k_in : $urandom_range(1, q.size() - 1);
    padrao = 2'(p);
    iniciar = 1'b1;
    for (int i = 0; i < q.size() + 2; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      parar = 1'b0;
      e = i < k ? q[i] : 7'b0;
      vetores++;
      if (obs !== e) begin erros++; $display("FAIL parar padrao%0d k=%0d ciclo %0d: obtido %b esperado %b", p, k, i + 1, obs, e); end
      if (i == k - 1) parar = 1'b1;
    end
    parar = 1'b0;
  endtask
  task automatic test_inicia_e_para;
    padrao = 2'($urandom);
    iniciar = 1'b1;
    parar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      parar = 1'b0;
      vetores++;
      if (obs !== 7'b0) begin erros++; $display("FAIL inicia_e_para ciclo %0d: obtido %b esperado %b", i + 1, obs, 7'b0); end
    end
  endtask
  task automatic test_async_reset;
    fila_t q = traco(3);
    padrao = 2'd3;
    iniciar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      vetores++;
      if (obs !== q[i]) begin erros++; $display("FAIL pre_reset ciclo %0d: obtido %b esperado %b", i + 1, obs, q[i]); end
    end
    #2 reset = 1'b0;
    #1 vetores++;
    if (obs !== 7'b0) begin erros++; $display("FAIL reset_assincrono: obtido %b esperado %b", obs, 7'b0); end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vetores++;
      if (obs !== 7'b0) begin erros++; $display("FAIL pos_reset ciclo %0d: obtido %b esperado %b", i, obs, 7'b0); end
    end
  endtask
  task automatic test_preempt;
    fila_t q0 = traco(0);
    fila_t q1 = traco(1);
    saida_t e;
    padrao = 2'd0;
    iniciar = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
`ifdef BUZZER_SEQ_PREEMPCAO_EN
      e = i < 3 ? q0[i] : (i - 3 < q1.size() ? q1[i - 3] : 7'b0);
`else
      e = i < q0.size() ? q0[i] : 7'b0;
`endif
      vetores++;
      if (obs !== e) begin erros++; $display("FAIL preempcao ciclo %0d: obtido %b esperado %b", i + 1, obs, e); end
      if (i == 2) begin
        iniciar = 1'b1;
        padrao = 2'd1;
      end
    end
  endtask
  task automatic test_back_to_back(input int a, input int b);
    fila_t qa = traco(a);
    fila_t qb = traco(b);
    saida_t e;
    int l = qa.size();
    padrao = 2'(a);
    iniciar = 1'b1;
    for (int i = 0; i < l + qb.size() + 3; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      e = i < l ? qa[i] : (i == l ? 7'b0 : (i - l - 1 < qb.size() ? qb[i - l - 1] : 7'b0));
      vetores++;
      if (obs !== e) begin erros++; $display("FAIL seguidos %0d->%0d ciclo %0d: obtido %b esperado %b", a, b, i + 1, obs, e); end
      if (i == l) begin
        iniciar = 1'b1;
        padrao = 2'(b);
      end
    end
  endtask
  initial begin
    test_reset;
    test_padrao(0, 1'b0);
    test_padrao(1, 1'b0);
    test_padrao(2, 1'b0);
    test_padrao(3, 1'b1);
    repeat (6) test_padrao($urandom_range(0, 3), 1'b1);
    test_parar(2, 5);
    repeat (5) test_parar($urandom_range(0, 3), 0);
    test_inicia_e_para;
    test_async_reset;
    test_preempt;
    repeat (3) test_back_to_back($urandom_range(0, 3), $urandom_range(0, 3));
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end
endmodule
